// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and instruction length lookup.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam int unsigned FETCH_BYTES = 10;

    typedef enum logic {StLoad, StRun} fetch_state_e;

    // Undefined icodes are treated as single-byte so the PC still advances.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_HALT, I_NOP, I_RET:                 instr_len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:     instr_len = 4'd2;
            I_JXX, I_CALL:                        instr_len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         instr_len = 4'd10;
            default:                              instr_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/imem_fetch.sv
// Byte-addressed instruction memory: one loader write port and a 10-byte combinational
// read window starting at pc_i; bytes beyond the array read as zero.
module imem_fetch
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic                              clk_i,
    input  logic                              ld_we_i,
    input  logic [63:0]                       ld_addr_i,
    input  logic [7:0]                        ld_data_i,
    input  logic [63:0]                       pc_i,
    output logic [FETCH_BYTES-1:0][7:0]       window_o
);

    localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk_i) begin
        if (ld_we_i && (ld_addr_i < 64'(MEM_BYTES))) begin
            mem[ld_addr_i[AW-1:0]] <= ld_data_i;
        end
    end

    for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_rd
        logic [63:0] rd_addr;
        assign rd_addr     = pc_i + 64'(i);
        assign window_o[i] = (rd_addr < 64'(MEM_BYTES)) ? mem[rd_addr[AW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, instruction split into f_* fields, predicted-PC
// register, and a LOAD/RUN gate that bubbles the output until the loader finishes.
module fetch_stage
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [63:0] START_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_we,
    input  logic [63:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_done,
    input  logic        F_stall,
    input  logic [3:0]  M_iCode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_iCode,
    input  logic [63:0] W_valM,
    output logic [3:0]  f_iCode,
    output logic [3:0]  f_iFun,
    output logic [3:0]  f_rA,
    output logic [3:0]  f_rB,
    output logic [2:0]  f_stat,
    output logic [63:0] f_valC,
    output logic [63:0] f_valP,
    output logic [63:0] F_predPC,
    output logic        running
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pred_pc_q, pred_pc_d;

    logic [63:0]                 fetch_pc;
    logic [FETCH_BYTES-1:0][7:0] win;
    logic [3:0]                  icode, ifun, len;
    logic [64:0]                 end_sum;
    logic [63:0]                 valc, valp;
    logic                        adr, ins, ifun_ok, has_reg, take_target;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == StLoad && ld_done) begin
            state_d = StRun;
        end
    end

    // FSM: outputs
    always_comb begin
        running = (state_q == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc_q <= START_PC;
        end else begin
            pred_pc_q <= pred_pc_d;
        end
    end

    assign F_predPC = pred_pc_q;

    // Late corrections from M (not-taken jump) and W (ret) override the prediction.
    always_comb begin
        if (M_iCode == I_JXX && !M_Cnd) begin
            fetch_pc = M_valA;
        end else if (W_iCode == I_RET) begin
            fetch_pc = W_valM;
        end else begin
            fetch_pc = pred_pc_q;
        end
    end

    imem_fetch #(
        .MEM_BYTES (MEM_BYTES)
    ) u_imem (
        .clk_i     (clk),
        .ld_we_i   (ld_we),
        .ld_addr_i (ld_addr),
        .ld_data_i (ld_data),
        .pc_i      (fetch_pc),
        .window_o  (win)
    );

    always_comb begin
        icode   = win[0][7:4];
        ifun    = win[0][3:0];
        len     = instr_len(icode);
        end_sum = {1'b0, fetch_pc} + 65'(len);
        valp    = end_sum[63:0];
        // Carry out means the instruction wraps past the top of the address space.
        adr     = end_sum[64] || ((end_sum - 65'd1) >= 65'(MEM_BYTES));
        has_reg = icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
        case (icode)
            I_JXX, I_CALL:                valc = win[8:1];
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: valc = win[9:2];
            default:                      valc = 64'd0;
        endcase
        case (icode)
            I_RRMOVQ, I_JXX: ifun_ok = (ifun <= 4'd6);
            I_OPQ:           ifun_ok = (ifun <= 4'd3);
            default:         ifun_ok = (ifun == 4'd0);
        endcase
        ins         = (icode > I_POPQ) || !ifun_ok;
        take_target = !adr && !ins && (icode == I_JXX || icode == I_CALL);
    end

    always_comb begin
        f_iCode = I_NOP;
        f_iFun  = 4'd0;
        f_rA    = REG_NONE;
        f_rB    = REG_NONE;
        f_stat  = S_AOK;
        f_valC  = 64'd0;
        f_valP  = pred_pc_q;
        if (state_q == StRun) begin
            f_valP = valp;
            if (adr) begin
                f_stat = S_ADR;
            end else begin
                f_iCode = icode;
                f_iFun  = ifun;
                f_valC  = valc;
                if (has_reg) begin
                    f_rA = win[1][7:4];
                    f_rB = win[1][3:0];
                end
                if (ins) begin
                    f_stat = S_INS;
                end else if (icode == I_HALT) begin
                    f_stat = S_HLT;
                end
            end
        end
    end

    always_comb begin
        pred_pc_d = pred_pc_q;
        if (state_q == StRun && !F_stall) begin
            pred_pc_d = take_target ? valc : valp;
        end
    end

endmodule
